mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Main controller for the multicycle MIPS datapath built around the shared alu. One ALU,
//  register file and unified memory are reused across cycles; this FSM sequences them per
//  instruction (lw, sw, R-type, beq, addi, j). It issues the 3-bit alu_ctl code, mux
//  selects and write enables, and stalls on a memory ready handshake.
// PARAMETERS
//  OP_W      6  opcode field width (instr[31:26])
//  FUNCT_W   6  funct field width (instr[5:0])
//  ALUCTL_W  3  alu control width: 010 add, 110 sub, 000 and, 001 or, 111 slt
// PORTS
//  clk         in   1         clock; all state changes on the rising edge
//  reset_n     in   1         synchronous reset, active low
//  op          in   OP_W      opcode from the instruction register
//  funct       in   FUNCT_W   funct field from the instruction register
//  zero        in   1         alu zero flag
//  mem_ready   in   1         memory completes the current access this cycle
//  mem_req     out  1         memory access requested (FETCH, MEMRD, MEMWR)
//  mem_write   out  1         write access; valid only with mem_req
//  iord        out  1         address mux: 0 = pc, 1 = alu_out
//  ir_write    out  1         load instruction register
//  reg_write   out  1         register file write enable
//  reg_dst     out  1         write address mux: 0 = rt, 1 = rd
//  mem_to_reg  out  1         write data mux: 0 = alu_out, 1 = mem data
//  alu_src_a   out  1         0 = pc, 1 = rs
//  alu_src_b   out  2         00 rt, 01 const 4, 10 sign-extended imm, 11 imm<<2
//  alu_ctl     out  ALUCTL_W  operation code to alu
//  pc_src      out  2         00 alu result, 01 alu_out, 10 jump target
//  pc_en       out  1         pc load = pc_write | (branch & zero)
//  illegal_op  out  1         one-cycle pulse: unknown opcode or funct
//  state_o     out  4         current state (debug)
// BEHAVIOUR
//  - States (4-bit): FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXECUTE=6 ALUWB=7
//    BRANCH=8 ADDIEX=9 ADDIWB=10 JUMP=11. Codes 12-15 are unreachable; they go to FETCH.
//  - Reset: reset_n=0 at an edge forces FETCH. While reset_n=0, every enable output
//    (mem_req, mem_write, ir_write, reg_write, pc_en) is forced to 0 combinationally and
//    illegal_op=0. Reset mid-instruction discards the instruction with no partial writes.
//  - Outputs are a Moore decode of state. Exceptions: pc_en, ir_write and the FETCH
//    pc_write also depend on mem_ready; pc_en depends on zero in BRANCH. Unlisted signals = 0.
//  - FETCH: mem_req, iord=0, src_a=0, src_b=01, add, pc_src=00. Hold until mem_ready=1.
//    In that cycle assert ir_write and pc_write, then go to DECODE.
//  - DECODE: src_a=0, src_b=11, add (branch target into alu_out). Next state by op:
//    100011/101011 -> MEMADR, 000000 -> EXECUTE, 000100 -> BRANCH, 001000 -> ADDIEX,
//    000010 -> JUMP. Any other op -> FETCH with illegal_op pulsed.
//  - MEMADR: src_a=1, src_b=10, add. Next MEMRD if op=lw, else MEMWR.
//  - MEMRD: mem_req, iord=1. Hold until mem_ready, then MEMWB.
//  - MEMWB: reg_write, reg_dst=0, mem_to_reg=1. Next FETCH.
//  - MEMWR: mem_req, mem_write, iord=1. Hold until mem_ready, then FETCH.
//  - EXECUTE: src_a=1, src_b=00, alu_ctl from funct: 100000->010, 100010->110, 100100->000,
//    100101->001, 101010->111. Unknown funct -> 010 with illegal_op pulsed, next FETCH.
//    Otherwise next ALUWB.
//  - ALUWB: reg_write, reg_dst=1, mem_to_reg=0. Next FETCH.
//  - BRANCH: src_a=1, src_b=00, sub, pc_src=01, branch=1 (pc_en=zero). Next FETCH.
//  - ADDIEX: src_a=1, src_b=10, add. Next ADDIWB.
//  - ADDIWB: reg_write, reg_dst=0, mem_to_reg=0. Next FETCH.
//  - JUMP: pc_src=10, pc_write. Next FETCH.
//  - Latency with mem_ready tied to 1: lw 5, sw 4, R 4, addi 4, beq 3, j 3 cycles.
//    Each mem_ready=0 cycle in a memory state adds one cycle.
//  - mem_ready outside a memory state is ignored. mem_req and mem_write stay stable
//    while waiting.
// STRUCTURE
//  - Package mips_ctrl_pkg: state_t enum, opcode/funct localparams, alu_ctl codes,
//    src_b/pc_src encodings.
//  - Sub-module mc_alu_decoder (combinational): {alu_op_sel[1:0], funct} -> alu_ctl,
//    funct_illegal.
//  - Top: state register, next-state logic, output decode.
// TESTING
//  - reset_n=0 for 2 cycles, then 1, mem_ready=1 -> state_o=0. All enables 0 while in
//    reset. ir_write=1 and pc_en=1 in the first cycle after release.
//  - lw (op=100011), mem_ready=1 -> states 0,1,2,3,4,0. reg_write=1 with mem_to_reg=1
//    only in state 4.
//  - R-type slt (funct=101010) -> alu_ctl=111 in EXECUTE. reg_write with reg_dst=1 in
//    ALUWB. 4 cycles total.
//  - beq: zero=1 -> pc_en=1 and pc_src=01 in BRANCH. Repeat with zero=0 -> pc_en=0.
//    Both 3 cycles.
//  - sw with mem_ready low for 3 cycles in MEMWR -> mem_req=1 and mem_write=1 held for
//    4 cycles, then FETCH.
//  - op=111111 -> illegal_op pulses 1 cycle in DECODE, next FETCH. Assert reset_n=0 in
//    MEMRD -> FETCH, reg_write never asserted.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// funct codes, ALU control codes and datapath mux selects.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU operation selector from the FSM; NONE drives alu_ctl to zero.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_NONE  = 2'b11;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU control decoder: maps the FSM's operation selector and the funct
// field to the 3-bit alu_ctl code, flagging unknown funct values.
module mc_alu_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int FUNCT_W  = 6,
  parameter int ALUCTL_W = 3
) (
  input  logic [1:0]          i_alu_op_sel,
  input  logic [FUNCT_W-1:0]  i_funct,
  output logic [ALUCTL_W-1:0] o_alu_ctl,
  output logic                o_funct_illegal
);

  // Selector / funct to ALU code; unknown funct falls back to add.
  always_comb begin
    o_alu_ctl       = 3'b000;
    o_funct_illegal = 1'b0;
    case (i_alu_op_sel)
      ALUOP_ADD: o_alu_ctl = ALU_ADD;
      ALUOP_SUB: o_alu_ctl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FN_ADD: o_alu_ctl = ALU_ADD;
          FN_SUB: o_alu_ctl = ALU_SUB;
          FN_AND: o_alu_ctl = ALU_AND;
          FN_OR:  o_alu_ctl = ALU_OR;
          FN_SLT: o_alu_ctl = ALU_SLT;
          default: begin
            o_alu_ctl       = ALU_ADD;
            o_funct_illegal = 1'b1;
          end
        endcase
      end
      default: o_alu_ctl = 3'b000;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main controller: sequences the shared ALU, register file
// and unified memory per instruction, stalling on the memory ready handshake.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int FUNCT_W  = 6,
  parameter int ALUCTL_W = 3
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic [OP_W-1:0]     i_op,
  input  logic [FUNCT_W-1:0]  i_funct,
  input  logic                i_zero,
  input  logic                i_mem_ready,
  output logic                o_mem_req,
  output logic                o_mem_write,
  output logic                o_iord,
  output logic                o_ir_write,
  output logic                o_reg_write,
  output logic                o_reg_dst,
  output logic                o_mem_to_reg,
  output logic                o_alu_src_a,
  output logic [1:0]          o_alu_src_b,
  output logic [ALUCTL_W-1:0] o_alu_ctl,
  output logic [1:0]          o_pc_src,
  output logic                o_pc_en,
  output logic                o_illegal_op,
  output logic [3:0]          o_state
);

  state_t              r_state;
  state_t              w_next;
  logic                w_op_illegal;
  logic                w_funct_illegal;
  logic [1:0]          w_alu_op_sel;
  logic [ALUCTL_W-1:0] w_alu_ctl;
  logic w_mem_req, w_mem_write, w_ir_write, w_reg_write, w_pc_write, w_branch;

  mc_alu_decoder #(
    .FUNCT_W  (FUNCT_W),
    .ALUCTL_W (ALUCTL_W)
  ) u_alu_dec (
    .i_alu_op_sel    (w_alu_op_sel),
    .i_funct         (i_funct),
    .o_alu_ctl       (w_alu_ctl),
    .o_funct_illegal (w_funct_illegal)
  );

  // State register with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= S_FETCH;
    else            r_state <= w_next;
  end

  // Next-state logic; unreachable codes recover to FETCH.
  always_comb begin
    w_next       = S_FETCH;
    w_op_illegal = 1'b0;
    case (r_state)
      S_FETCH:  w_next = i_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (i_op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default: begin
            w_next       = S_FETCH;
            w_op_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR:  w_next = (i_op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next = i_mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   w_next = S_FETCH;
      S_MEMWR:   w_next = i_mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: w_next = w_funct_illegal ? S_FETCH : S_ALUWB;
      S_ADDIEX:  w_next = S_ADDIWB;
      S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: w_next = S_FETCH;
      default:   w_next = S_FETCH;
    endcase
  end

  // Moore output decode; only FETCH and BRANCH look at mem_ready / zero.
  always_comb begin
    w_mem_req    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_pc_write   = 1'b0;
    w_branch     = 1'b0;
    o_iord       = 1'b0;
    o_reg_dst    = 1'b0;
    o_mem_to_reg = 1'b0;
    o_alu_src_a  = 1'b0;
    o_alu_src_b  = SRCB_RT;
    o_pc_src     = PCSRC_ALU;
    w_alu_op_sel = ALUOP_NONE;
    case (r_state)
      S_FETCH: begin
        w_mem_req    = 1'b1;
        o_alu_src_b  = SRCB_FOUR;
        w_alu_op_sel = ALUOP_ADD;
        w_ir_write   = i_mem_ready;
        w_pc_write   = i_mem_ready;
      end
      S_DECODE: begin
        o_alu_src_b  = SRCB_IMMSL2;
        w_alu_op_sel = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        o_alu_src_a  = 1'b1;
        o_alu_src_b  = SRCB_IMM;
        w_alu_op_sel = ALUOP_ADD;
      end
      S_MEMRD: begin
        w_mem_req = 1'b1;
        o_iord    = 1'b1;
      end
      S_MEMWB: begin
        w_reg_write  = 1'b1;
        o_mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        w_mem_req   = 1'b1;
        w_mem_write = 1'b1;
        o_iord      = 1'b1;
      end
      S_EXECUTE: begin
        o_alu_src_a  = 1'b1;
        w_alu_op_sel = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        o_reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        o_alu_src_a  = 1'b1;
        w_alu_op_sel = ALUOP_SUB;
        o_pc_src     = PCSRC_ALUOUT;
        w_branch     = 1'b1;
      end
      S_ADDIWB: w_reg_write = 1'b1;
      S_JUMP: begin
        o_pc_src   = PCSRC_JUMP;
        w_pc_write = 1'b1;
      end
      default: w_alu_op_sel = ALUOP_NONE;
    endcase
  end

  // Enables are gated by reset so an aborted instruction never writes.
  assign o_mem_req    = i_reset_n & w_mem_req;
  assign o_mem_write  = i_reset_n & w_mem_write;
  assign o_ir_write   = i_reset_n & w_ir_write;
  assign o_reg_write  = i_reset_n & w_reg_write;
  assign o_pc_en      = i_reset_n & (w_pc_write | (w_branch & i_zero));
  assign o_illegal_op = i_reset_n & (w_op_illegal | w_funct_illegal);
  assign o_alu_ctl    = w_alu_ctl;
  assign o_state      = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized self-checking bench: an instruction-level sequence model
// predicts the state walk and control outputs cycle by cycle.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       mem_req, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctl;
  logic       pc_en, illegal_op;
  logic [3:0] state_o;

  int checks = 0;
  int failures = 0;
  int zmode = -1;
  int wr_cycles = 0;

  mips_multicycle_ctrl dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_op(op), .i_funct(funct), .i_zero(zero),
    .i_mem_ready(mem_ready), .o_mem_req(mem_req), .o_mem_write(mem_write), .o_iord(iord),
    .o_ir_write(ir_write), .o_reg_write(reg_write), .o_reg_dst(reg_dst),
    .o_mem_to_reg(mem_to_reg), .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b),
    .o_alu_ctl(alu_ctl), .o_pc_src(pc_src), .o_pc_en(pc_en), .o_illegal_op(illegal_op),
    .o_state(state_o)
  );

  always #5 clk = ~clk;

  wire [20:0] obs = {mem_req, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg,
                     alu_src_a, alu_src_b, alu_ctl, pc_src, pc_en, illegal_op, state_o};
  wire [5:0] enables = {mem_req, mem_write, ir_write, reg_write, pc_en, illegal_op};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit op_legal(input logic [5:0] o);
    return o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  function automatic bit funct_legal(input logic [5:0] f);
    return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  // Expected control vector for a given state number, straight from the state table.
  function automatic logic [20:0] exp_vec(input int s, input logic mr, input logic z,
                                         input logic [5:0] o, input logic [5:0] f);
    logic mreq, mwr, ird, irw, rw, rdst, m2r, sa, pen, ill;
    logic [1:0] sb, ps;
    logic [2:0] ac;
    {mreq, mwr, ird, irw, rw, rdst, m2r, sa, pen, ill} = 10'd0;
    sb = 2'b00; ps = 2'b00; ac = 3'b000;
    case (s)
      0:  begin mreq = 1'b1; sb = 2'b01; ac = 3'b010; irw = mr; pen = mr; end
      1:  begin sb = 2'b11; ac = 3'b010; ill = !op_legal(o); end
      2:  begin sa = 1'b1; sb = 2'b10; ac = 3'b010; end
      3:  begin mreq = 1'b1; ird = 1'b1; end
      4:  begin rw = 1'b1; m2r = 1'b1; end
      5:  begin mreq = 1'b1; mwr = 1'b1; ird = 1'b1; end
      6: begin
        sa = 1'b1;
        case (f)
          6'b100000: ac = 3'b010;
          6'b100010: ac = 3'b110;
          6'b100100: ac = 3'b000;
          6'b100101: ac = 3'b001;
          6'b101010: ac = 3'b111;
          default: begin ac = 3'b010; ill = 1'b1; end
        endcase
      end
      7:  begin rw = 1'b1; rdst = 1'b1; end
      8:  begin sa = 1'b1; ac = 3'b110; ps = 2'b01; pen = z; end
      9:  begin sa = 1'b1; sb = 2'b10; ac = 3'b010; end
      10: rw = 1'b1;
      11: begin ps = 2'b10; pen = 1'b1; end
      default: ;
    endcase
    return {mreq, mwr, ird, irw, rw, rdst, m2r, sa, sb, ac, ps, pen, ill, 4'(s)};
  endfunction

  task automatic step(input logic mr, input int exp_state, input string tag);
    @(negedge clk);
    mem_ready = mr;
    zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : zmode[0];
    #1;
    check_eq(tag, {11'd0, obs}, {11'd0, exp_vec(exp_state, mr, zero, op, funct)});
    if (mem_write) wr_cycles++;
    @(posedge clk);
  endtask

  // kind: 0 lw, 1 sw, 2 R, 3 beq, 4 addi, 5 j, 6 illegal op, 7 R with illegal funct.
  // stall < 0 randomizes mem_ready waits, otherwise every memory phase waits that long.
  task automatic run_instr(input int kind, input int stall, input logic [5:0] fsel);
    int ph[$];
    int n;
    logic mr;
    funct = 6'($urandom_range(0, 63));
    case (kind)
      0: begin op = 6'b100011; ph = '{0, 1, 2, 3, 4}; end
      1: begin op = 6'b101011; ph = '{0, 1, 2, 5}; end
      2: begin op = 6'b000000; funct = fsel; ph = '{0, 1, 6, 7}; end
      3: begin op = 6'b000100; ph = '{0, 1, 8}; end
      4: begin op = 6'b001000; ph = '{0, 1, 9, 10}; end
      5: begin op = 6'b000010; ph = '{0, 1, 11}; end
      6: begin
        do op = 6'($urandom_range(0, 63)); while (op_legal(op));
        ph = '{0, 1};
      end
      default: begin
        op = 6'b000000;
        do funct = 6'($urandom_range(0, 63)); while (funct_legal(funct));
        ph = '{0, 1, 6};
      end
    endcase
    foreach (ph[i]) begin
      if (ph[i] == 0 || ph[i] == 3 || ph[i] == 5) begin
        n = 0;
        forever begin
          if (stall >= 0) mr = (n >= stall);
          else            mr = (n >= 6) || ($urandom_range(0, 2) != 0);
          step(mr, ph[i], $sformatf("k%0d_s%0d", kind, ph[i]));
          if (mr) break;
          n++;
        end
      end else begin
        step(1'($urandom_range(0, 1)), ph[i], $sformatf("k%0d_s%0d", kind, ph[i]));
      end
    end
    #2;
    check_eq($sformatf("k%0d_end_fetch", kind), {28'd0, state_o}, 32'd0);
  endtask

  logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  initial begin
    // Two reset cycles with mem_ready high: all enables held low.
    reset_n = 1'b0; mem_ready = 1'b1; op = 6'b100011;
    @(negedge clk); #1;
    check_eq("rst1_enables", {26'd0, enables}, 32'd0);
    @(posedge clk);
    @(negedge clk); #1;
    check_eq("rst2_enables", {26'd0, enables}, 32'd0);
    check_eq("rst2_state", {28'd0, state_o}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Directed: first instruction fetches immediately after release.
    run_instr(0, 0, 6'd0);
    run_instr(2, 0, 6'b101010);
    zmode = 1; run_instr(3, 0, 6'd0);
    zmode = 0; run_instr(3, 0, 6'd0);
    zmode = -1;
    wr_cycles = 0;
    run_instr(1, 3, 6'd0);
    check_eq("sw_write_hold", wr_cycles, 32'd4);
    run_instr(6, 0, 6'd0);
    run_instr(7, 0, 6'd0);

    // Reset asserted in MEMRD: instruction discarded, no register write.
    op = 6'b100011;
    step(1'b1, 0, "mid_s0");
    step(1'b1, 1, "mid_s1");
    step(1'b1, 2, "mid_s2");
    @(negedge clk);
    reset_n = 1'b0; mem_ready = 1'b1; #1;
    check_eq("mid_rst_enables", {26'd0, enables}, 32'd0);
    check_eq("mid_rst_state", {28'd0, state_o}, 32'd3);
    @(posedge clk); #1;
    check_eq("mid_rst_fetch", {28'd0, state_o}, 32'd0);
    check_eq("mid_rst_no_regwr", {31'd0, reg_write}, 32'd0);
    reset_n = 1'b1;

    // Randomized instruction stream.
    for (int k = 0; k < 150; k++) begin
      run_instr($urandom_range(0, 7), -1, fns[$urandom_range(0, 4)]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
